// File: rtl/pmp_csr_pkg.sv
// Shared types and constants for the PMP configuration CSR block.
// Covers privilege levels, PMP address-matching modes, CSR op encoding and CSR addresses.
package pmp_csr_pkg;

   typedef enum logic [1:0] {
      PRIV_LVL_U = 2'b00,
      PRIV_LVL_S = 2'b01,
      PRIV_LVL_H = 2'b10,
      PRIV_LVL_M = 2'b11
   } privilege_e;

   typedef enum logic [1:0] {
      PMP_MODE_OFF   = 2'b00,
      PMP_MODE_TOR   = 2'b01,
      PMP_MODE_NA4   = 2'b10,
      PMP_MODE_NAPOT = 2'b11
   } pmp_mode_e;

   typedef enum logic [1:0] {
      CSR_OP_READ  = 2'b00,
      CSR_OP_WRITE = 2'b01,
      CSR_OP_SET   = 2'b10,
      CSR_OP_CLEAR = 2'b11
   } csr_op_e;

   localparam logic [11:0] CSR_PMPCFG0   = 12'h3A0;
   localparam logic [11:0] CSR_PMPCFG3   = 12'h3A3;
   localparam logic [11:0] CSR_PMPADDR0  = 12'h3B0;
   localparam logic [11:0] CSR_PMPADDR15 = 12'h3BF;

endpackage

// File: rtl/pmp_csr_if.sv
// CSR access bus between the hart's CSR unit (master) and the PMP CSR file (slave).
interface pmp_csr_if;
   import pmp_csr_pkg::*;

   privilege_e  privilege_mode;
   logic        csr_req_i;
   logic        csr_gnt_o;
   logic [1:0]  csr_op_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i;
   logic        csr_rvalid_o;
   logic [31:0] csr_rdata_o;
   logic        csr_err_o;

   modport slave (
      input  privilege_mode, csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i,
      output csr_gnt_o, csr_rvalid_o, csr_rdata_o, csr_err_o
   );

   modport master (
      output privilege_mode, csr_req_i, csr_op_i, csr_addr_i, csr_wdata_i,
      input  csr_gnt_o, csr_rvalid_o, csr_rdata_o, csr_err_o
   );

endinterface

// File: rtl/pmp_cfg_legalize.sv
// WARL and lock legalization for one pmpcfg byte lane.
module pmp_cfg_legalize (
   input  logic [7:0] old_i,
   input  logic [7:0] wdata_i,
   output logic [7:0] cfg_o
);

   logic locked;
   logic w_only;

   assign locked = old_i[7];
   assign w_only = wdata_i[1] & ~wdata_i[0];

   // With G=0 NA4 is a legal mode, so the A field passes through unchanged.
   assign cfg_o = (locked || w_only) ? old_i : {wdata_i[7], 2'b00, wdata_i[4:0]};

endmodule

// File: rtl/pmp_csr.sv
// PMP cfg/addr CSR file: three-state access FSM, WARL legalization, lock handling and
// registered outputs to the PMP checker.
module pmp_csr
   import pmp_csr_pkg::*;
#(
   parameter int unsigned PMP_ENTRY = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   pmp_csr_if.slave                    bus,
   output logic [PMP_ENTRY-1:0][7:0]   pmpcfg_o,
   output logic [PMP_ENTRY-1:0][33:0]  pmpaddr_o,
   output logic                        pmp_update_o
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e                       state_q;
   csr_op_e                      op_q;
   logic [11:0]                  req_addr_q;
   logic [31:0]                  wdata_q;
   privilege_e                   priv_q;
   logic                         rvalid_q, err_q, update_q;
   logic [31:0]                  rdata_q;
   logic                         wr_cfg_q, wr_addr_q;
   logic [3:0][7:0]              wr_data_q;
   logic [PMP_ENTRY-1:0][7:0]    cfg_q;
   logic [PMP_ENTRY-1:0][31:0]   pmpaddr_q;

   logic [PMP_ENTRY-1:0]         addr_lock;
   logic [3:0][7:0]              old_cfg, new_cfg;
   logic [31:0]                  old_addr, old_val, new_raw, new_val;
   logic                         sel_lock, cfg_hit, addr_hit, cfg_ok, addr_ok;
   logic                         acc_err, modifies, do_write;

   for (genvar g = 0; g < PMP_ENTRY; g++) begin : g_entry
      // An address is also frozen when the locked entry above uses it as its TOR base.
      if (g < PMP_ENTRY - 1) begin : g_tor
         assign addr_lock[g] = cfg_q[g][7] |
                               (cfg_q[g+1][7] & (cfg_q[g+1][4:3] == PMP_MODE_TOR));
      end else begin : g_last
         assign addr_lock[g] = cfg_q[g][7];
      end
      assign pmpcfg_o[g]  = cfg_q[g];
      assign pmpaddr_o[g] = {2'b00, pmpaddr_q[g]};
   end

   assign cfg_hit  = (req_addr_q >= CSR_PMPCFG0) && (req_addr_q <= CSR_PMPCFG3);
   assign addr_hit = (req_addr_q >= CSR_PMPADDR0) && (req_addr_q <= CSR_PMPADDR15);
   assign cfg_ok   = cfg_hit && ((32'(req_addr_q[1:0]) << 2) < PMP_ENTRY);
   assign addr_ok  = addr_hit && (32'(req_addr_q[3:0]) < PMP_ENTRY);
   assign acc_err  = !(cfg_ok || addr_ok) || (priv_q != PRIV_LVL_M);

   always_comb begin
      old_cfg  = '0;
      old_addr = '0;
      sel_lock = 1'b0;
      for (int unsigned e = 0; e < PMP_ENTRY; e++) begin
         if (e[3:2] == req_addr_q[1:0]) old_cfg[e[1:0]] = cfg_q[e];
         if (e[3:0] == req_addr_q[3:0]) begin
            old_addr = pmpaddr_q[e];
            sel_lock = addr_lock[e];
         end
      end
   end

   assign old_val = cfg_hit ? old_cfg : old_addr;

   always_comb begin
      unique case (op_q)
         CSR_OP_WRITE: new_raw = wdata_q;
         CSR_OP_SET:   new_raw = old_val | wdata_q;
         CSR_OP_CLEAR: new_raw = old_val & ~wdata_q;
         default:      new_raw = old_val;
      endcase
   end

   for (genvar l = 0; l < 4; l++) begin : g_lane
      pmp_cfg_legalize u_legalize (
         .old_i   (old_cfg[l]),
         .wdata_i (new_raw[8*l +: 8]),
         .cfg_o   (new_cfg[l])
      );
   end

   assign new_val  = cfg_hit ? new_cfg : (sel_lock ? old_addr : new_raw);
   assign modifies = (op_q == CSR_OP_WRITE) ||
                     (((op_q == CSR_OP_SET) || (op_q == CSR_OP_CLEAR)) && (wdata_q != '0));
   assign do_write = !acc_err && modifies && (new_val != old_val);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         op_q       <= CSR_OP_READ;
         req_addr_q <= '0;
         wdata_q    <= '0;
         priv_q     <= PRIV_LVL_U;
         rvalid_q   <= 1'b0;
         err_q      <= 1'b0;
         update_q   <= 1'b0;
         rdata_q    <= '0;
         wr_cfg_q   <= 1'b0;
         wr_addr_q  <= 1'b0;
         wr_data_q  <= '0;
         cfg_q      <= '0;
         pmpaddr_q  <= '0;
      end else begin
         update_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.csr_req_i) begin
                  op_q       <= csr_op_e'(bus.csr_op_i);
                  req_addr_q <= bus.csr_addr_i;
                  wdata_q    <= bus.csr_wdata_i;
                  priv_q     <= bus.privilege_mode;
                  state_q    <= StExec;
               end
            end
            StExec: begin
               rvalid_q  <= 1'b1;
               err_q     <= acc_err;
               rdata_q   <= acc_err ? '0 : old_val;
               wr_cfg_q  <= do_write && cfg_hit;
               wr_addr_q <= do_write && addr_hit;
               wr_data_q <= new_val;
               state_q   <= StResp;
            end
            StResp: begin
               for (int unsigned e = 0; e < PMP_ENTRY; e++) begin
                  if (wr_cfg_q && (e[3:2] == req_addr_q[1:0])) cfg_q[e] <= wr_data_q[e[1:0]];
                  if (wr_addr_q && (e[3:0] == req_addr_q[3:0])) pmpaddr_q[e] <= wr_data_q;
               end
               update_q  <= wr_cfg_q || wr_addr_q;
               rvalid_q  <= 1'b0;
               err_q     <= 1'b0;
               rdata_q   <= '0;
               wr_cfg_q  <= 1'b0;
               wr_addr_q <= 1'b0;
               state_q   <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.csr_gnt_o    = (state_q == StIdle);
   assign bus.csr_rvalid_o = rvalid_q;
   assign bus.csr_rdata_o  = rdata_q;
   assign bus.csr_err_o    = err_q;
   assign pmp_update_o     = update_q;

endmodule

// File: doc/pmp_csr.md
PMP_CSR -- requirements
Module: pmp_csr

Interface
REQ-001 SHALL have parameter PMP_ENTRY, default 16, number of PMP entries (legal values 4, 8, 16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port privilege_mode  input  privilege_e  current hart privilege.
REQ-005 SHALL have port csr_req_i  input  1  CSR access request, valid for one cycle when csr_gnt_o=1.
REQ-006 SHALL have port csr_gnt_o  output  1  request accepted; high only in IDLE.
REQ-007 SHALL have port csr_op_i  input  2  00=read, 01=write, 10=set, 11=clear.
REQ-008 SHALL have port csr_addr_i  input  12  CSR address.
REQ-009 SHALL have port csr_wdata_i  input  32  write, set or clear operand.
REQ-010 SHALL have port csr_rvalid_o  output  1  one-cycle response strobe.
REQ-011 SHALL have port csr_rdata_o  output  32  read data, i.e. the old value; valid with csr_rvalid_o.
REQ-012 SHALL have port csr_err_o  output  1  illegal access; valid with csr_rvalid_o.
REQ-013 SHALL have port pmpcfg_o  output  [PMP_ENTRY-1:0][7:0]  per-entry cfg to the PMP checker.
REQ-014 SHALL have port pmpaddr_o  output  [PMP_ENTRY-1:0][33:0]  per-entry address to the checker; bits [33:32] are always 0.
REQ-015 SHALL have port pmp_update_o  output  1  one-cycle pulse on the cycle after any cfg or addr register changes.

Function
REQ-016 SHALL decode pmpcfg0..3 at 0x3A0..0x3A3 (4 entries per register, entry 4k+i in bits [8i+7:8i]) and pmpaddr0..15 at 0x3B0..0x3BF.
REQ-017 SHALL report csr_err_o=1 with no state change for: an unmapped address, an entry index >= PMP_ENTRY, or privilege_mode != PRIV_LVL_M.
REQ-018 SHALL implement an FSM IDLE -> EXEC -> RESP -> IDLE:
- IDLE: csr_gnt_o=1; csr_req_i latches op, addr and wdata.
- EXEC: read the old value and compute the new value.
- RESP: commit the write; assert csr_rvalid_o for exactly one cycle.
REQ-019 SHALL give a total latency of 2 cycles from the accepted request to csr_rvalid_o, with back-to-back requests accepted every 3 cycles.
REQ-020 SHALL compute the new value for write as wdata, for set as old|wdata, and for clear as old&~wdata; read SHALL never modify state.
REQ-021 SHALL treat set/clear with wdata=0 as reads, producing no update pulse.
REQ-022 SHALL apply WARL cfg legalization per byte:
- bits [6:5] always read 0;
- a byte with W=1, R=0 SHALL leave that entry's cfg unchanged;
- if the A field is NA4 and G>0 it SHALL be stored as OFF (G=0 here, so NA4 is legal).
REQ-023 SHALL ignore writes to a cfg byte whose L bit (bit7) is set, while other bytes in the same register still update.
REQ-024 SHALL ignore writes to pmpaddr[n] when cfg[n].L=1, or when cfg[n+1].L=1 and cfg[n+1].A=TOR (for n+1 < PMP_ENTRY).
REQ-025 SHALL let a locked entry be cleared only by reset.
REQ-026 SHALL return the old value in csr_rdata_o even when the write is ignored; csr_err_o SHALL stay 0 in that case.
REQ-027 SHALL pulse pmp_update_o only if a stored bit actually changed.
REQ-028 SHALL register pmpcfg_o and pmpaddr_o directly from storage, with no combinational path from csr_* inputs.

Reset
REQ-029 SHALL, on rst_n=0, immediately set:
- all cfg bytes and addr registers to 0;
- FSM to IDLE;
- csr_rvalid_o, csr_err_o, pmp_update_o and csr_rdata_o to 0;
- csr_gnt_o to 1 after release.
REQ-030 SHALL, on reset asserted mid-transaction, discard the transaction with no commit and no response.

Structure
REQ-031 SHALL take privilege_e, the PMP mode enum (OFF, TOR, NA4, NAPOT), the CSR address constants and the csr_op encoding from the shared package.
REQ-032 SHALL place per-byte WARL and lock legalization in one sub-module, pmp_cfg_legalize, instantiated once per cfg byte lane.

Verification
REQ-033 SHALL verify: write 0x3A0 = 0x0000_1F0B -> rdata=0 (old value); next read returns 0x0000_1F0B, the entry1 byte 0x1F stored as 0x1F (R,W,X=1, NAPOT); one pmp_update_o pulse.
REQ-034 SHALL verify: cfg0 written with 0x82 (L=1, W=1, R=0) -> byte unchanged (0x00) and no pulse; then write 0x81 -> locked; a subsequent write of 0x00 -> still reads 0x81.
REQ-035 SHALL verify: cfg1 = 0x89 (L=1, TOR) then write pmpaddr0 = 0x1234 -> pmpaddr0 remains 0, rvalid=1, err=0.
REQ-036 SHALL verify: U-mode read of 0x3B0, and M-mode access to 0x3C0 -> err=1, rdata=0, no state change.
REQ-037 SHALL verify: set op on 0x3B2 with 0xF0 over old value 0x0F -> 0xFF stored; clear with 0x0F -> 0xF0 stored.
REQ-038 SHALL verify: rst_n dropped during EXEC of a write -> no rvalid; all outputs 0; after release, a read returns 0.
